button_debouncer: RTL

//   Turns a raw, bouncing, asynchronous push-button input into clean, clock-synchronous button events.
//   It produces a debounced level, one-cycle press and release pulses, and a one-shot long-press pulse.
//   It sits between the board button pin and the consumers in the camera control path.
//   The toggle/mode logic consumes btn_pressed (the debounced press event).
//

---
 rtl/button_debouncer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/button_debouncer.sv
// Push-button debouncer: 2-FF synchroniser, four-state stability FSM,
// registered level / press / release pulses and a one-shot long-press pulse.
module button_debouncer #(
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES   = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_pressed,
  output logic btn_released,
  output logic btn_long
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_PRE  = HW'((LONG_CYCLES > 0) ? LONG_CYCLES - 1 : 0);
  localparam bit            LONG_EN   = (LONG_CYCLES > 0);

  typedef enum logic [1:0] {IDLE, ARM_PRESS, PRESSED, ARM_RELEASE} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_sync1, r_sync2;
  logic [SW-1:0] r_stab_cnt, w_stab_nxt;
  logic [HW-1:0] r_hold_cnt, w_hold_nxt;
  logic          w_level_nxt, w_pressed_nxt, w_released_nxt, w_long_nxt;
  logic          w_btn_s;

  assign w_btn_s = r_sync2;

  // State, counters, synchroniser and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_state      <= IDLE;
      r_stab_cnt   <= '0;
      r_hold_cnt   <= '0;
      btn_level    <= 1'b0;
      btn_pressed  <= 1'b0;
      btn_released <= 1'b0;
      btn_long     <= 1'b0;
    end else begin
      r_sync1      <= btn_in;
      r_sync2      <= r_sync1;
      r_state      <= w_state_nxt;
      r_stab_cnt   <= w_stab_nxt;
      r_hold_cnt   <= w_hold_nxt;
      btn_level    <= w_level_nxt;
      btn_pressed  <= w_pressed_nxt;
      btn_released <= w_released_nxt;
      btn_long     <= w_long_nxt;
    end
  end

  // Next state and stability counter
  always_comb begin
    w_state_nxt = r_state;
    w_stab_nxt  = r_stab_cnt;
    case (r_state)
      IDLE: begin
        if (w_btn_s) begin
          w_state_nxt = ARM_PRESS;
          w_stab_nxt  = SW'(1);
        end
      end
      ARM_PRESS: begin
        if (!w_btn_s) begin
          w_state_nxt = IDLE;
          w_stab_nxt  = '0;
        end else if (r_stab_cnt == STAB_LAST) begin
          w_state_nxt = PRESSED;
          w_stab_nxt  = '0;
        end else begin
          w_stab_nxt  = r_stab_cnt + SW'(1);
        end
      end
      PRESSED: begin
        if (!w_btn_s) begin
          w_state_nxt = ARM_RELEASE;
          w_stab_nxt  = SW'(1);
        end
      end
      ARM_RELEASE: begin
        if (w_btn_s) begin
          w_state_nxt = PRESSED;
          w_stab_nxt  = '0;
        end else if (r_stab_cnt == STAB_LAST) begin
          w_state_nxt = IDLE;
          w_stab_nxt  = '0;
        end else begin
          w_stab_nxt  = r_stab_cnt + SW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_stab_nxt  = '0;
      end
    endcase
  end

  // Next output values and hold counter (registered above, so glitch-free)
  always_comb begin
    w_level_nxt    = btn_level;
    w_pressed_nxt  = 1'b0;
    w_released_nxt = 1'b0;
    w_long_nxt     = 1'b0;
    w_hold_nxt     = r_hold_cnt;
    case (r_state)
      ARM_PRESS: begin
        if (w_btn_s && r_stab_cnt == STAB_LAST) begin
          w_level_nxt   = 1'b1;
          w_pressed_nxt = 1'b1;
          w_hold_nxt    = '0;
        end
      end
      PRESSED: begin
        // saturating hold counter; reaching HOLD_MAX happens once per press
        if (w_btn_s && LONG_EN && r_hold_cnt != HOLD_MAX) begin
          w_hold_nxt = r_hold_cnt + HW'(1);
          if (r_hold_cnt == HOLD_PRE) w_long_nxt = 1'b1;
        end
      end
      ARM_RELEASE: begin
        if (!w_btn_s && r_stab_cnt == STAB_LAST) begin
          w_level_nxt    = 1'b0;
          w_released_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
